// File: rtl/y86_mem_pkg.sv
// Shared types and constants for the Y86-64 data-memory responder.
package y86_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } y86_mem_state_t;

  localparam int Y86_WORD_BYTES = 8;
  localparam int Y86_WORD_W     = 64;
  localparam int Y86_BEAT_W     = 3;

  // Request fields held for the duration of an access.
  typedef struct packed {
    logic                  write;
    logic [Y86_WORD_W-1:0] wdata;
  } y86_mem_req_t;

endpackage

// File: rtl/y86_byte_ram.sv
// Single-port byte array: synchronous write, combinational read.
module y86_byte_ram #(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/y86_dmem_responder.sv
// Y86-64 data-memory responder: 8 byte beats per good access, 1-cycle bad-address reply, RESP holds until rsp_ready.
// Optional Y86_DMEM_STATS_EN adds a saturating access_count of response handshakes.
module y86_dmem_responder
  import y86_mem_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [Y86_WORD_W-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [Y86_WORD_W-1:0] rsp_rdata,
  output logic                  rsp_bad_mem
`ifdef Y86_DMEM_STATS_EN
  ,
  output logic [31:0]           access_count
`endif
);

  localparam int RAM_AW = $clog2(MEM_BYTES);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

  y86_mem_state_t         state;
  logic [Y86_BEAT_W-1:0]  beat;
  logic [RAM_AW-1:0]      lat_addr;
  y86_mem_req_t           lat_req;

  logic [ADDR_W:0]        req_end;
  logic                   req_bad;
  logic [RAM_AW-1:0]      ram_addr;
  logic [7:0]             ram_wdata;
  logic [7:0]             ram_rdata;
  logic                   ram_we;

  // One extra bit catches address wrap-around as out of range.
  assign req_end = {1'b0, req_addr} + (ADDR_W+1)'(Y86_WORD_BYTES);
  assign req_bad = req_end > LIMIT;

  assign req_ready = (state == IDLE);
  assign ram_addr  = lat_addr + RAM_AW'(beat);
  assign ram_wdata = lat_req.wdata[{beat, 3'b000} +: 8];
  assign ram_we    = (state == ACCESS) && lat_req.write;

  y86_byte_ram #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (RAM_AW)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat        <= '0;
      lat_addr    <= '0;
      lat_req     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_bad_mem <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            // Good requests fit below MEM_BYTES, so the low bits are the full RAM address.
            lat_addr      <= req_addr[RAM_AW-1:0];
            lat_req.write <= req_write;
            lat_req.wdata <= req_wdata;
            rsp_rdata     <= '0;
            rsp_bad_mem   <= req_bad;
            beat          <= '0;
            state         <= req_bad ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (!lat_req.write) rsp_rdata[{beat, 3'b000} +: 8] <= ram_rdata;
          beat <= beat + 1'b1;
          if (beat == 3'd7) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          // A bad request enters RESP with rsp_valid still low; it rises one cycle later.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef Y86_DMEM_STATS_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      access_count <= '0;
    end else if (rsp_valid && rsp_ready && (access_count != 32'hFFFF_FFFF)) begin
      access_count <= access_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_y86_dmem_responder.sv
// Scoreboard bench for y86_dmem_responder: latency, data, bad-address, stall and reset-abort behaviour.
module tb_y86_dmem_responder;

  localparam int MEM_BYTES = 1024;
  localparam int ADDR_W    = 64;

  logic        clock;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_bad_mem;
`ifdef Y86_DMEM_STATS_EN
  logic [31:0] access_count;
`endif

  typedef struct {
    logic [63:0] rdata;
    logic        bad;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_rsp    = 0;

  y86_dmem_responder #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_bad_mem (rsp_bad_mem)
`ifdef Y86_DMEM_STATS_EN
    ,
    .access_count (access_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, then compare the response against the scoreboard entry.
  task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic exp_bad, input int stall);
    exp_t        e;
    int          lat;
    logic [63:0] hold_rd;
    logic        hold_bad;
    exp_q.push_back('{rdata: exp_rd, bad: exp_bad, lat: (exp_bad ? 1 : 8)});
    @(posedge clock); #1;
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    rsp_ready = (stall == 0);
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    e = exp_q.pop_front();
    if (!rsp_valid) begin
      check("rsp_timeout", 64'(rsp_valid), 64'd1);
    end else begin
      check("rsp_latency", 64'(lat), 64'(e.lat));
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_bad_mem", 64'(rsp_bad_mem), 64'(e.bad));
      n_rsp++;
      if (stall > 0) begin
        hold_rd  = rsp_rdata;
        hold_bad = rsp_bad_mem;
        for (int i = 0; i < stall; i++) begin
          @(posedge clock); #1;
          check("stall_valid", 64'(rsp_valid), 64'd1);
          check("stall_rdata", rsp_rdata, hold_rd);
          check("stall_bad", 64'(rsp_bad_mem), 64'(hold_bad));
          check("stall_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
      end
      @(posedge clock); #1;
      check("req_ready_after_rsp", 64'(req_ready), 64'd1);
      check("rsp_valid_dropped", 64'(rsp_valid), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] d;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    #1;
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_rdata", rsp_rdata, 64'd0);
    check("reset_rsp_bad", 64'(rsp_bad_mem), 64'd0);
`ifdef Y86_DMEM_STATS_EN
    check("reset_access_count", 64'(access_count), 64'd0);
`endif
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;

    do_req(1'b1, 64'h18, 64'h0000_0000_0000_005A, 64'd0, 1'b0, 0);
    do_req(1'b1, 64'h10, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 0);
    do_req(1'b0, 64'h10, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 0);
    do_req(1'b0, 64'h11, 64'd0, 64'h5A01_2345_6789_ABCD, 1'b0, 0);

    do_req(1'b1, 64'd1016, 64'hCAFE_F00D_1234_5678, 64'd0, 1'b0, 0);
    do_req(1'b1, 64'd1017, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0);
    do_req(1'b0, 64'd1016, 64'd0, 64'hCAFE_F00D_1234_5678, 1'b0, 0);
    do_req(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 1'b1, 0);

    do_req(1'b0, 64'h10, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 3);

    for (int i = 0; i < 4; i++) begin
      a = 64'($urandom_range(0, MEM_BYTES - 8));
      d = {$urandom, $urandom};
      do_req(1'b1, a, d, 64'd0, 1'b0, 0);
      do_req(1'b0, a, 64'd0, d, 1'b0, 0);
    end

    do_req(1'b1, 64'h20, 64'd0, 64'd0, 1'b0, 0);
`ifdef Y86_DMEM_STATS_EN
    check("access_count", 64'(access_count), 64'(n_rsp));
`endif

    // Write all-ones to 0x20 and reset after four bytes have been stored.
    @(posedge clock); #1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h20;
    req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1 rst_n = 1'b0;
    #1;
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
`ifdef Y86_DMEM_STATS_EN
    check("abort_access_count", 64'(access_count), 64'd0);
`endif
    @(posedge clock); #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("abort_no_rsp", 64'(rsp_valid), 64'd0);
    end
    do_req(1'b0, 64'h20, 64'd0, 64'h0000_0000_FFFF_FFFF, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/y86_dmem_responder.md
# y86_dmem_responder

Memory-side responder for the Y86-64 SEQ core's data-memory port. It accepts one 64-bit read or write request at a time over a valid/ready handshake. It performs the access as eight little-endian byte beats into a byte-wide RAM and returns read data or a bad-address status over a second valid/ready channel. It sits between the core's memory stage and the backing store, and replaces the core-internal array.

## Interface
- `MEM_BYTES`, 1024: size of the byte array; must be ≥ 8.
- `ADDR_W`, 64: request address width.
- `clock`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  byte address of the least significant byte.
- `req_wdata`  in  64  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  core accepts the response.
- `rsp_rdata`  out  64  read data; 0 for writes and for bad addresses.
- `rsp_bad_mem`  out  1  address out of range (maps to the core's `bad_mem2`).
- `access_count`  out  32  only with `Y86_DMEM_STATS_EN`.

## Operation
- FSM states:
  - IDLE: `req_ready` = 1, decoded from state.
  - ACCESS: 8 beats, counter `beat` runs 0..7.
  - RESP: `rsp_valid` = 1.
- A request is accepted on a rising edge when `req_valid && req_ready`. On accept, `req_addr`, `req_write` and `req_wdata` are latched.
- Range check is done at accept, in ADDR_W+1-bit arithmetic: the request is bad if `addr + 8 > MEM_BYTES`. A carry out of ADDR_W bits also counts as bad, so there is no wrap-around.
- Bad request: IDLE→RESP. `rsp_bad_mem` = 1, `rsp_rdata` = 0, memory is not touched.
- Good request: IDLE→ACCESS with `beat` = 0. Each ACCESS cycle handles byte address `addr + beat`:
  - Write: stores `wdata[8*beat +: 8]`.
  - Read: captures the RAM byte into `rdata[8*beat +: 8]`.
  - `beat` == 7 → RESP.
- RESP: `rsp_rdata` and `rsp_bad_mem` are held stable while `rsp_valid` is high. The FSM returns to IDLE on the edge where `rsp_ready` is 1.
- `rsp_rdata` is cleared to 0 on accept of every request, so a write response reads 0.
- Only one request is outstanding; no new request is accepted in ACCESS or RESP.

## Timing
- Reset (async assert, sync deassert is outside this block):
  - State = IDLE, `beat` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_bad_mem` = 0, `access_count` = 0.
  - `req_ready` = 1 while in IDLE, including during reset.
  - RAM contents are not reset.
- Good request accepted at edge N: byte beats occur at edges N+1..N+8, and `rsp_valid` rises after edge N+8.
- Bad request accepted at edge N: `rsp_valid` rises after edge N+1.
- Handshake:
  - Back-to-back: the response handshake at edge M makes `req_ready` = 1 after M, so the next accept is at edge M+1 at the earliest.
  - Throughput: 10 cycles per good access with `rsp_ready` held high.
  - `rsp_ready` low stalls RESP indefinitely with outputs held.
- Reset mid-ACCESS: the FSM aborts to IDLE and no response is produced. Write bytes already stored stay stored; there is no rollback.
- The RAM write is synchronous. The RAM read is combinational from the current beat address.

## Configuration
- `Y86_DMEM_STATS_EN` defined:
  - Adds the `access_count` port.
  - The counter increments by 1 on every response handshake, good or bad.
  - It saturates at 0xFFFF_FFFF and is cleared by reset.
- Not defined: no port and no counter logic. All other behaviour is identical.

## Structure
- Package `y86_mem_pkg` holds:
  - The FSM state type {IDLE, ACCESS, RESP}.
  - `Y86_WORD_BYTES` = 8.
  - `Y86_WORD_W` = 64.
  - The byte-lane helper constant for beat index width (3).
- Sub-module `y86_byte_ram`: single-port byte array of `MEM_BYTES` entries, with synchronous write enable and combinational read. Address width is `$clog2(MEM_BYTES)`.
- The top holds the FSM, beat counter, latched request, range check and response registers.

## Test plan
- Write 0x0123456789ABCDEF to addr 0x10, then read addr 0x10: `rsp_rdata` = 0x0123456789ABCDEF, `rsp_bad_mem` = 0. `rsp_valid` rises exactly 8 cycles after each accept.
- After that write, read addr 0x11: `rsp_rdata` = 0x??0123456789ABCD with upper byte = RAM[0x18]. Pre-load 0x18 = 0x5A to get 0x5A0123456789ABCD, confirming little-endian order.
- Write to addr `MEM_BYTES-7` (1017): `rsp_bad_mem` = 1 one cycle after accept, `rsp_rdata` = 0. Reading addr 1016 returns unchanged contents. Addr 0xFFFF_FFFF_FFFF_FFFC also gives `rsp_bad_mem` = 1.
- Hold `rsp_ready` low for 3 cycles in RESP: `rsp_valid`, `rsp_rdata` and `rsp_bad_mem` stay constant and `req_ready` = 0. Raise `rsp_ready`: `req_ready` = 1 on the next cycle.
- Assert `rst_n` = 0 after beat 3 of a write of 0xFFFF_FFFF_FFFF_FFFF to addr 0x20, which previously held 0: no response, `req_ready` = 1 immediately. A read of 0x20 then returns 0x0000_0000_FFFF_FFFF.
- With `Y86_DMEM_STATS_EN`: 2 good requests plus 1 bad request give `access_count` = 3. Reset gives 0.
